// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobed matrix keypad scanner with a two-flop column
// synchroniser, press/release debounce, a one-clock key_valid strobe and a
// key_held level. One row is driven low at a time. While a key is held, the
// scanner stays locked on that key until it has been released.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 8,
    parameter int KEY_W    = $clog2(ROWS*COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COLS-1:0]  col_n,
    output logic [ROWS-1:0]  row_n,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_held
);

    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEBOUNCE);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [COLS-1:0]  col_meta_q, col_sync_q;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [DBW-1:0]   deb_q, deb_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;

    logic             any_low;
    logic [CW-1:0]    low_idx;
    logic             sel_high;
    logic [RW-1:0]    row_adv;

    // Two-flop synchroniser for the asynchronous column lines; idles high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_meta_q <= '1;
            col_sync_q <= '1;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // Lowest-index closed column on the current sample, and next row index.
    always_comb begin
        any_low = ~&col_sync_q;
        low_idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!col_sync_q[i]) begin
                low_idx = CW'(i);
            end
        end
        sel_high = col_sync_q[col_q];
        row_adv  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
    end

    // Next-state logic: scan dwell, press debounce, hold lockout, release debounce.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        deb_d   = deb_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;
        case (state_q)
            S_SCAN: begin
                if (dwell_q == DW'(SCAN_DIV - 1)) begin
                    if (any_low) begin
                        col_d   = low_idx;
                        deb_d   = '0;
                        state_d = S_DEBOUNCE;
                    end else begin
                        row_d   = row_adv;
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (sel_high) begin
                    state_d = S_SCAN;
                    row_d   = row_adv;
                    dwell_d = '0;
                end else if (deb_q == DBW'(DEBOUNCE - 1)) begin
                    state_d = S_PRESSED;
                    key_d   = KEY_W'(row_q) * KEY_W'(COLS) + KEY_W'(col_q);
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            S_PRESSED: begin
                if (sel_high) begin
                    deb_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!sel_high) begin
                    state_d = S_PRESSED;
                end else if (deb_q == DBW'(DEBOUNCE - 1)) begin
                    held_d  = 1'b0;
                    state_d = S_SCAN;
                    row_d   = row_adv;
                    dwell_d = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                state_d = S_SCAN;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_SCAN;
            row_q   <= '0;
            col_q   <= '0;
            dwell_q <= '0;
            deb_q   <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dwell_q <= dwell_d;
            deb_q   <= deb_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    // One-hot-low row drive decoded from the registered row index.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign row_n[gi] = (row_q != RW'(gi));
    end

    assign key       = key_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed tests for a 4x4 scanner and a 3x5 scanner.
// A behavioural keypad pulls a column low whenever a closed key's row is driven.
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;
    logic [15:0] closed;

    logic [4:0] col_n2;
    logic [2:0] row_n2;
    logic [3:0] key2;
    logic       key_valid2;
    logic       key_held2;
    logic [14:0] closed2;

    int checks = 0;
    int errors = 0;

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(8)) dut (
        .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
        .key(key), .key_valid(key_valid), .key_held(key_held)
    );

    keypad_scanner #(.ROWS(3), .COLS(5), .SCAN_DIV(4), .DEBOUNCE(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .col_n(col_n2), .row_n(row_n2),
        .key(key2), .key_valid(key_valid2), .key_held(key_held2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad models: column low when a closed key sits on the driven row.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (closed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    always_comb begin
        col_n2 = '1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                if (closed2[r*5+c] && !row_n2[r]) col_n2[c] = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_held_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!key_held) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL reset_row_n got %b want 1110", row_n); end
        checks++; if (key !== 4'd0) begin errors++; $display("FAIL reset_key got %0d want 0", key); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", key_held); end
        checks++; if (row_n2 !== 3'b110) begin errors++; $display("FAIL reset_row_n2 got %b want 110", row_n2); end
        $display("test_reset: row_n=%b key=%0d", row_n, key);
    endtask

    task automatic test_scan();
        logic [3:0] exp_rows [4];
        int bad_rows = 0;
        int strobes = 0;
        exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (row_n !== exp_rows[(k / 4) % 4]) begin
                bad_rows++;
                $display("FAIL scan_row k=%0d got %b want %b", k, row_n, exp_rows[(k / 4) % 4]);
            end
            if (key_valid) strobes++;
            tick();
        end
        checks++; if (bad_rows != 0) begin errors++; $display("FAIL scan_rows got %0d bad want 0", bad_rows); end
        checks++; if (strobes != 0) begin errors++; $display("FAIL scan_no_strobe got %0d want 0", strobes); end
        $display("test_scan: 32 clocks, bad rows %0d, strobes %0d", bad_rows, strobes);
    endtask

    task automatic test_press();
        int strobes = 0;
        logic [3:0] k_seen = '0;
        closed = '0;
        closed[9] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (key_valid) begin strobes++; k_seen = key; end
        end
        checks++; if (strobes != 1) begin errors++; $display("FAIL press_strobes got %0d want 1", strobes); end
        checks++; if (k_seen !== 4'd9) begin errors++; $display("FAIL press_key got %0d want 9", k_seen); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held got %b want 1", key_held); end
        closed = '0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 10) begin
                checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_early got %b want 1", key_held); end
            end
            if (i == 11) begin
                checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_late got %b want 0", key_held); end
            end
        end
        checks++; if (key !== 4'd9) begin errors++; $display("FAIL release_key_kept got %0d want 9", key); end
        $display("test_press: key=%0d strobes=%0d", k_seen, strobes);
        repeat (4) tick();
    endtask

    task automatic test_short();
        int strobes = 0;
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (row_n != 4'b1101) break;
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            if (row_n == 4'b1101) begin found = 1'b1; break; end
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL short_find_row1 got timeout want row1"); end
        closed[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); if (key_valid) strobes++; end
        closed = '0;
        for (int i = 0; i < 4; i++) begin tick(); if (key_valid) strobes++; end
        checks++; if (strobes != 0) begin errors++; $display("FAIL short_strobe got %0d want 0", strobes); end
        checks++; if (row_n !== 4'b1011) begin errors++; $display("FAIL short_next_row got %b want 1011", row_n); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL short_held got %b want 0", key_held); end
        $display("test_short: 5-clock closure, strobes=%0d row_n=%b", strobes, row_n);
    endtask

    task automatic test_glitch();
        bit ok;
        int strobes = 0;
        int held_drops = 0;
        closed[5] = 1'b1;
        wait_valid(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL glitch_press got timeout want strobe"); end
        checks++; if (key !== 4'd5) begin errors++; $display("FAIL glitch_key got %0d want 5", key); end
        repeat (2) tick();
        closed = '0;
        repeat (3) tick();
        closed[5] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (key_valid) strobes++;
            if (!key_held) held_drops++;
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL glitch_strobe got %0d want 0", strobes); end
        checks++; if (held_drops != 0) begin errors++; $display("FAIL glitch_held got %0d low cycles want 0", held_drops); end
        closed = '0;
        wait_held_low(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL glitch_release got timeout want held low"); end
        $display("test_glitch: key=%0d extra strobes=%0d", key, strobes);
        repeat (2) tick();
    endtask

    task automatic test_multi();
        bit ok;
        int strobes = 0;
        closed[7] = 1'b1;
        closed[4] = 1'b1;
        wait_valid(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL multi_press got timeout want strobe"); end
        checks++; if (key !== 4'd4) begin errors++; $display("FAIL multi_lowest_col got %0d want 4", key); end
        closed[14] = 1'b1;
        for (int i = 0; i < 40; i++) begin tick(); if (key_valid) strobes++; end
        checks++; if (strobes != 0) begin errors++; $display("FAIL multi_lockout got %0d want 0", strobes); end
        closed[4] = 1'b0;
        closed[7] = 1'b0;
        wait_valid(80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL multi_second got timeout want strobe"); end
        checks++; if (key !== 4'd14) begin errors++; $display("FAIL multi_second_key got %0d want 14", key); end
        closed = '0;
        wait_held_low(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL multi_release got timeout want held low"); end
        $display("test_multi: second key=%0d", key);
        repeat (2) tick();
    endtask

    task automatic test_reset_pressed();
        bit ok;
        closed[9] = 1'b1;
        wait_valid(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstp_press got timeout want strobe"); end
        rst_n = 1'b0;
        tick();
        checks++; if (key !== 4'd0) begin errors++; $display("FAIL rstp_key got %0d want 0", key); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rstp_held got %b want 0", key_held); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstp_valid got %b want 0", key_valid); end
        checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL rstp_row_n got %b want 1110", row_n); end
        closed = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL rstp_scan_restart i=%0d got %b want 1110", i, row_n); end
            tick();
        end
        $display("test_reset_pressed: key=%0d held=%b", key, key_held);
    endtask

    task automatic test_small();
        bit seen_other = 1'b0;
        bit ok = 1'b0;
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            if (row_n2 != 3'b110) break;
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            if (row_n2 == 3'b110) break;
            tick();
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (row_n2 != 3'b110) seen_other = 1'b1;
            if (seen_other && row_n2 == 3'b110) break;
        end
        checks++; if (n != 12) begin errors++; $display("FAIL small_period got %0d want 12", n); end
        closed2[14] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (key_valid2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL small_press got timeout want strobe"); end
        checks++; if (key2 !== 4'd14) begin errors++; $display("FAIL small_key got %0d want 14", key2); end
        checks++; if (key_held2 !== 1'b1) begin errors++; $display("FAIL small_held got %b want 1", key_held2); end
        closed2 = '0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!key_held2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL small_release got timeout want held low"); end
        $display("test_small: period=%0d key=%0d", n, key2);
    endtask

    initial begin
        rst_n   = 1'b0;
        closed  = '0;
        closed2 = '0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_press();
        test_short();
        test_glitch();
        test_multi();
        test_reset_pressed();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
